tt_sweep_checker: RTL and testbench

TT_SWEEP_CHECKER -- requirements
Module: tt_sweep_checker

---
 rtl/tt_sweep_checker.sv | 113 +++++++++++
 tb/tb_tt_sweep_checker.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// rtl/tt_sweep_checker.sv - exhaustive truth-table sweep comparing a netlist output against a golden model
module tt_sweep_checker #(
    parameter int N_IN   = 7,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            hold,
    output logic [N_IN-1:0] x,
    input  logic            y_dut,
    input  logic            y_ref,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mism_cnt,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_vld,
    output logic [N_IN:0]   ones_cnt,
    output logic [15:0]     sig
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE);
    localparam logic [N_IN-1:0] X_LAST      = '1;
    localparam logic [15:0]     CRC_POLY    = 16'h1021;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic       res_vld;
    logic       accept;
    logic       sample;
    logic       last_vec;

    always_comb begin
        accept    = (state == IDLE) && start;
        sample    = (state == RUN) && !hold && (settle_cnt == SETTLE_LAST);
        last_vec  = (x == X_LAST);
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (sample && last_vec) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Results persist through DONE and IDLE; only an accepted start or reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x              <= '0;
            settle_cnt     <= '0;
            mism_cnt       <= '0;
            ones_cnt       <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            sig            <= '0;
            res_vld        <= 1'b0;
        end else if (accept) begin
            x              <= '0;
            settle_cnt     <= '0;
            mism_cnt       <= '0;
            ones_cnt       <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            sig            <= 16'hFFFF;
            res_vld        <= 1'b0;
        end else if (state == RUN && !hold) begin
            if (sample) begin
                settle_cnt <= '0;
                if (last_vec) begin
                    res_vld <= 1'b1;
                end else begin
                    x <= x + N_IN'(1);
                end
                if (y_dut != y_ref) begin
                    mism_cnt <= mism_cnt + (N_IN+1)'(1);
                    if (!first_fail_vld) begin
                        first_fail     <= x;
                        first_fail_vld <= 1'b1;
                    end
                end
                if (y_dut) begin
                    ones_cnt <= ones_cnt + (N_IN+1)'(1);
                end
                sig <= {sig[14:0], 1'b0} ^ ((sig[15] ^ y_dut) ? CRC_POLY : 16'h0000);
            end else begin
                settle_cnt <= settle_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
        pass = res_vld && (mism_cnt == '0);
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb/tb_tt_sweep_checker.sv - randomized self-checking bench for tt_sweep_checker
module tb_tt_sweep_checker;

    localparam int N  = 7;
    localparam int S  = 1;
    localparam int NV = 1 << N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         hold = 1'b0;
    logic [N-1:0] x;
    logic         y_dut;
    logic         y_ref;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   mism_cnt;
    logic [N-1:0] first_fail;
    logic         first_fail_vld;
    logic [N:0]   ones_cnt;
    logic [15:0]  sig;

    logic tt_dut [NV];
    logic tt_ref [NV];
    logic m_dut  [NV];
    logic m_ref  [NV];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int mode = 0;
    int k = 0;
    bit zeroed = 1'b1;

    tt_sweep_checker #(.N_IN(N), .SETTLE(S)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .hold           (hold),
        .x              (x),
        .y_dut          (y_dut),
        .y_ref          (y_ref),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .mism_cnt       (mism_cnt),
        .first_fail     (first_fail),
        .first_fail_vld (first_fail_vld),
        .ones_cnt       (ones_cnt),
        .sig            (sig)
    );

    assign y_dut = tt_dut[x];
    assign y_ref = tt_ref[x];

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sweep model: mode 0 idle, 1 run, 2 done; k counts non-held run cycles since start.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            zeroed <= 1'b1;
            mode   <= 0;
            k      <= 0;
        end else begin
            case (mode)
                0: if (start) begin
                    mode   <= 1;
                    k      <= 0;
                    zeroed <= 1'b0;
                    for (int i = 0; i < NV; i++) begin
                        m_dut[i] <= tt_dut[i];
                        m_ref[i] <= tt_ref[i];
                    end
                end
                1: if (!hold) begin
                    k <= k + 1;
                    if (k + 1 == NV * (S + 1)) mode <= 2;
                end
                default: mode <= 0;
            endcase
        end
    end

    function automatic void calc(input int nv, output int mism, output int ones,
                                 output int ff, output int ffv, output int sg);
        int fb;
        int d;
        mism = 0; ones = 0; ff = 0; ffv = 0; sg = 'hFFFF;
        for (int v = 0; v < nv; v++) begin
            d = (m_dut[v] === 1'b1) ? 1 : 0;
            if (m_dut[v] !== m_ref[v]) begin
                mism++;
                if (ffv == 0) begin
                    ff  = v;
                    ffv = 1;
                end
            end
            ones += d;
            fb = ((sg >> 15) & 1) ^ d;
            sg = ((sg << 1) & 'hFFFF) ^ (fb != 0 ? 'h1021 : 0);
        end
    endfunction

    task automatic compare_outputs();
        int nv, em, eo, ef, efv, es, ex, eb, ed, ep;
        if (rst || zeroed) begin
            em = 0; eo = 0; ef = 0; efv = 0; es = 0; ex = 0; eb = 0; ed = 0; ep = 0;
        end else begin
            nv = (mode == 1) ? k / (S + 1) : NV;
            ex = (mode == 1) ? nv : NV - 1;
            calc(nv, em, eo, ef, efv, es);
            eb = (mode == 1) ? 1 : 0;
            ed = (mode == 2) ? 1 : 0;
            ep = (mode != 1 && em == 0) ? 1 : 0;
        end
        chk("x", x, ex);
        chk("busy", busy, eb);
        chk("done", done, ed);
        chk("pass", pass, ep);
        chk("mism_cnt", mism_cnt, em);
        chk("ones_cnt", ones_cnt, eo);
        chk("first_fail", first_fail, ef);
        chk("first_fail_vld", first_fail_vld, efv);
        chk("sig", sig, es);
    endtask

    always @(negedge clk) compare_outputs();

    task automatic set_tables(input int kind);
        for (int i = 0; i < NV; i++) begin
            case (kind)
                0: begin tt_dut[i] = i[0]; tt_ref[i] = i[0]; end
                1: begin tt_dut[i] = i[0]; tt_ref[i] = ~i[0]; end
                2: begin tt_dut[i] = 1'($urandom % 2); tt_ref[i] = (i == 'h55) ? ~tt_dut[i] : tt_dut[i]; end
                default: begin
                    tt_dut[i] = 1'($urandom % 2);
                    tt_ref[i] = ($urandom % 8 == 0) ? ~tt_dut[i] : tt_dut[i];
                end
            endcase
        end
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        acc_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", done, 1);
        lat = cyc - acc_cyc;
    endtask

    task automatic wait_x(input int val);
        int n = 0;
        while (x !== val[N-1:0] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("x_reached", x, val);
    endtask

    initial begin
        int lat;
        int c1;
        int n;
        set_tables(0);
        repeat (3) @(negedge clk);
        chk("rst_x", x, 0);
        chk("rst_sig", sig, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        kick();
        wait_done(lat);
        chk("basic_latency", lat, 256);
        chk("basic_ones", ones_cnt, 64);
        chk("basic_mism", mism_cnt, 0);
        chk("basic_pass", pass, 1);
        chk("basic_ffv", first_fail_vld, 0);
        hold = 1'b1;
        repeat (4) @(negedge clk);
        hold = 1'b0;
        chk("idle_stable_ones", ones_cnt, 64);

        set_tables(1);
        kick();
        wait_done(lat);
        chk("inv_mism", mism_cnt, 128);
        chk("inv_pass", pass, 0);
        chk("inv_ff", first_fail, 0);
        chk("inv_ffv", first_fail_vld, 1);

        set_tables(2);
        kick();
        wait_done(lat);
        chk("one_mism", mism_cnt, 1);
        chk("one_ff", first_fail, 'h55);
        chk("one_pass", pass, 0);

        set_tables(0);
        kick();
        wait_x(10);
        hold = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_x", x, 10);
        end
        hold = 1'b0;
        wait_done(lat);
        chk("hold_latency", lat, 261);
        chk("hold_ones", ones_cnt, 64);
        chk("hold_pass", pass, 1);

        kick();
        wait_x(40);
        #2 rst = 1'b1;
        #1;
        chk("arst_x", x, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ones", ones_cnt, 0);
        chk("arst_sig", sig, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        kick();
        wait_done(lat);
        chk("post_rst_latency", lat, 256);
        chk("post_rst_ones", ones_cnt, 64);
        chk("post_rst_pass", pass, 1);

        @(negedge clk);
        start = 1'b1;
        acc_cyc = cyc + 1;
        wait_done(lat);
        chk("b2b_latency1", lat, 256);
        c1 = cyc;
        n = 0;
        while (busy !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_gap", cyc - c1, 2);
        acc_cyc = cyc;
        wait_done(lat);
        start = 1'b0;
        chk("b2b_latency2", lat, 256);
        chk("b2b_pass", pass, 1);
        repeat (3) @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            set_tables(3);
            kick();
            n = 0;
            while (done !== 1'b1 && n < 3000) begin
                @(negedge clk);
                hold  = ($urandom % 4 == 0);
                start = ($urandom % 8 == 0);
                n++;
            end
            hold  = 1'b0;
            start = 1'b0;
            chk("rand_done", done, 1);
            repeat (3) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
